// File: rtl/regwrite_queue.sv
// regwrite_queue: circular buffer between the writeback stage and the
// register file write port. It drains one write per cycle and gives decode
// rs/rt forwarding from any write that is still queued.
//
// Ports:
//   clk_i, rst_i                      clock, synchronous active-high reset
//   push_valid_i/push_ready_o         writeback handshake
//   push_addr_i/push_data_i           write to enqueue (addr 0 is accepted, then dropped)
//   drain_en_i                        register file write port is free this cycle
//   regwrite_o/writeaddr_o/writedata_o  register file write port (head entry)
//   rsaddr_i/rtaddr_i                 decode lookup addresses
//   rs_hit_o/rs_data_o, rt_hit_o/rt_data_o  youngest matching queued write
//   count_o/empty_o/full_o            occupancy

// Forwarding lookup for one read port. It scans the entries from oldest to
// youngest, so a later match overrides an earlier one and the youngest wins.
module rwq_fwd #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32,
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]         vld,
  input  logic [DEPTH-1:0][AW-1:0] ent_addr,
  input  logic [DEPTH-1:0][DW-1:0] ent_data,
  input  logic [PW-1:0]            rd_ptr,
  input  logic [AW-1:0]            addr,
  output logic                     hit,
  output logic [DW-1:0]            data
);
  logic [PW-1:0] idx;

  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = rd_ptr;
    for (int k = 0; k < DEPTH; k++) begin
      // DEPTH is a power of two, so the PW-bit add wraps for free.
      idx = rd_ptr + PW'(k);
      if (vld[idx] && (ent_addr[idx] == addr) && (addr != '0)) begin
        hit  = 1'b1;
        data = ent_data[idx];
      end
    end
  end
endmodule

module regwrite_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32,
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_valid_i,
  output logic          push_ready_o,
  input  logic [AW-1:0] push_addr_i,
  input  logic [DW-1:0] push_data_i,
  input  logic          drain_en_i,
  output logic          regwrite_o,
  output logic [AW-1:0] writeaddr_o,
  output logic [DW-1:0] writedata_o,
  input  logic [AW-1:0] rsaddr_i,
  input  logic [AW-1:0] rtaddr_i,
  output logic          rs_hit_o,
  output logic [DW-1:0] rs_data_o,
  output logic          rt_hit_o,
  output logic [DW-1:0] rt_data_o,
  output logic [PW:0]   count_o,
  output logic          empty_o,
  output logic          full_o
);
  logic [DEPTH-1:0]         vld;
  logic [DEPTH-1:0][AW-1:0] ent_addr;
  logic [DEPTH-1:0][DW-1:0] ent_data;
  logic [PW-1:0]            rd_ptr, wr_ptr;
  logic [PW:0]              cnt;
  logic                     store, pop;

  assign empty_o      = (cnt == '0);
  assign full_o       = (cnt == (PW+1)'(DEPTH));
  assign count_o      = cnt;
  assign push_ready_o = !full_o;
  assign regwrite_o   = !empty_o && drain_en_i;
  assign writeaddr_o  = ent_addr[rd_ptr];
  assign writedata_o  = ent_data[rd_ptr];

  // r0 writes complete the handshake but never occupy an entry.
  assign store = push_valid_i && push_ready_o && (push_addr_i != '0);
  assign pop   = regwrite_o;

  // Control state. A store never targets the popped slot: store needs a free
  // slot at wr_ptr, pop needs an occupied one at rd_ptr.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
      vld    <= '0;
    end else begin
      if (store) begin
        vld[wr_ptr] <= 1'b1;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        vld[rd_ptr] <= 1'b0;
        rd_ptr      <= rd_ptr + 1'b1;
      end
      case ({store, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Entry payload is not reset; the valid bits guard it.
  always_ff @(posedge clk_i) begin
    if (!rst_i && store) begin
      ent_addr[wr_ptr] <= push_addr_i;
      ent_data[wr_ptr] <= push_data_i;
    end
  end

  // Port 0 = rs, port 1 = rt.
  logic [1:0][AW-1:0] lk_addr;
  logic [1:0]         lk_hit;
  logic [1:0][DW-1:0] lk_data;

  assign lk_addr = {rtaddr_i, rsaddr_i};

  for (genvar p = 0; p < 2; p++) begin : g_fwd
    rwq_fwd #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_fwd (
      .vld      (vld),
      .ent_addr (ent_addr),
      .ent_data (ent_data),
      .rd_ptr   (rd_ptr),
      .addr     (lk_addr[p]),
      .hit      (lk_hit[p]),
      .data     (lk_data[p])
    );
  end

  assign rs_hit_o  = lk_hit[0];
  assign rs_data_o = lk_data[0];
  assign rt_hit_o  = lk_hit[1];
  assign rt_data_o = lk_data[1];
endmodule

// File: doc/regwrite_queue.md
Name: regwrite_queue

Overview:
- Buffers pending register-file writes from the writeback stage.
- Drains them one per cycle into the register file write port (writeaddr/writedata/regwrite).
- Provides rs/rt forwarding lookups so decode never reads a stale value while a write is still queued.
- Sits between the writeback stage (producer, valid/ready handshake) and the 32x32 register file (consumer).

Parameters:
- DEPTH, 4, number of queue entries; power of two, at least 2.
- AW, 5, register address width.
- DW, 32, register data width.

Ports:
- clk_i  input  1  clock; all state updates on posedge.
- rst_i  input  1  synchronous, active-high reset.
- push_valid_i  input  1  writeback has a write to queue.
- push_ready_o  output  1  queue accepts a push this cycle.
- push_addr_i  input  AW  destination register of the pushed write.
- push_data_i  input  DW  data of the pushed write.
- drain_en_i  input  1  register file write port is available this cycle.
- regwrite_o  output  1  write strobe to the register file.
- writeaddr_o  output  AW  register file write address (head entry).
- writedata_o  output  DW  register file write data (head entry).
- rsaddr_i  input  AW  decode rs lookup address.
- rtaddr_i  input  AW  decode rt lookup address.
- rs_hit_o  output  1  a queued entry matches rsaddr_i.
- rs_data_o  output  DW  data of the youngest matching entry for rs.
- rt_hit_o  output  1  a queued entry matches rtaddr_i.
- rt_data_o  output  DW  data of the youngest matching entry for rt.
- count_o  output  log2(DEPTH)+1  number of occupied entries.
- empty_o  output  1  count_o == 0.
- full_o  output  1  count_o == DEPTH.

Behaviour:
- Reset (rst_i high at posedge): read ptr = 0, write ptr = 0, count = 0, all entry valid bits cleared.
  - Output values after reset: regwrite_o=0, push_ready_o=1, empty_o=1, full_o=0, rs_hit_o=0, rt_hit_o=0.
  - Entry data is not cleared.
  - rst_i overrides a push or pop in the same cycle; an in-flight queue is discarded.
- Storage: circular buffer of {addr, data}. Pointers wrap modulo DEPTH. count is tracked explicitly, not derived from the pointers.
- push_ready_o = !full_o. This is combinational from state only, with no dependence on push_valid_i or drain_en_i.
- Push fires when push_valid_i && push_ready_o at posedge.
  - If push_addr_i != 0: write the entry at the write ptr, then write ptr+1.
  - If push_addr_i == 0: handshake completes but nothing is stored; count and pointers are unchanged.
- Drain: regwrite_o = !empty_o && drain_en_i, combinational.
  - writeaddr_o/writedata_o always show the head entry; they are don't-care when empty.
  - When regwrite_o=1, the head is popped at posedge (read ptr+1).
- Latency: a push accepted at edge N becomes the head no earlier than the cycle after N. The earliest regwrite_o for it is the cycle following N, so there is no same-cycle pass-through.
- Simultaneous push and pop (not full): count unchanged, both pointers advance. When full, no push is possible even if a pop occurs that cycle.
- Ordering: strict FIFO. Two writes to the same register drain in push order.
- Forwarding, combinational over all valid entries:
  - Hit on a valid entry whose addr == lookup addr and lookup addr != 0.
  - With multiple matches, the youngest (closest to the write ptr) wins.
  - The entry being popped this cycle still counts as a hit this cycle.
  - The pushing entry is not visible until after its posedge.
  - rs_data_o/rt_data_o = 0 when there is no hit.
- count_o, empty_o and full_o are consistent with state after every edge. Overflow and underflow are impossible by construction.

Test Plan:
- Reset, then idle → regwrite_o=0, push_ready_o=1, empty_o=1, count_o=0, rs_hit_o=0 for rsaddr_i=5.
- Push (addr 3, 0xDEADBEEF) with drain_en_i=0 → count_o=1 next cycle. Raise drain_en_i → regwrite_o=1, writeaddr_o=3, writedata_o=0xDEADBEEF for one cycle, then empty_o=1.
- Fill 4 pushes (addr 1..4, data 0x11..0x44) with drain_en_i=0 → full_o=1, push_ready_o=0. A fifth push_valid_i is not accepted. Drain yields addrs 1,2,3,4 in order.
- Push (7, 0xA) then (7, 0xB), rsaddr_i=7, rtaddr_i=7 → rs_hit_o=rt_hit_o=1, data 0xB. After the first pop, still 0xB. After the second pop, hit=0.
- Push addr 0 with data 0x55 → push accepted, count_o stays 0, lookup of addr 0 never hits.
- Queue holding 2 entries, push and drain together for 6 cycles → count_o stays 2, pointers wrap, drain order matches push order. Assert rst_i mid-sequence → next cycle count_o=0 and regwrite_o=0.
